calc_resp_encoder: RTL and testbench

//  Parametrised result encoder for the UART calculator datapath, sitting between alu and uart.
//  - Queues ALU results in a DEPTH-entry FIFO.
//  - Renders each result as uppercase ASCII hex followed by CR LF.
//  - Streams the bytes to the UART transmitter using a valid/ready handshake.
//  - Optionally suppresses leading zeros.
//  - Absorbs result bursts while the transmitter is busy.

---
 rtl/calc_pkg.sv | 11 +
 rtl/calc_res_fifo.sv | 33 +++
 rtl/calc_resp_encoder.sv | 85 ++++++++
 tb/tb_calc_resp_encoder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM state type and ASCII constants for the calculator result encoder
package calc_pkg;
  typedef enum logic [1:0] {IDLE, DIGIT, CR, LF} state_t;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_A_M10 = 8'h37;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  function automatic logic [7:0] hex_asc(input logic [3:0] nib);
    return (nib < 4'd10 ? ASC_0 : ASC_A_M10) + {4'h0, nib};
  endfunction
endpackage

// File: rtl/calc_res_fifo.sv
// calc_res_fifo: show-ahead register FIFO with extra-MSB pointers for full/empty detection
module calc_res_fifo #(
  parameter int RES_W = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [RES_W-1:0] din,
  output logic [RES_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [RES_W-1:0] mem [DEPTH];
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
  always_comb begin
    dout  = mem[rp[AW-1:0]];
    empty = wp == rp;
    full  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  end
endmodule

// File: rtl/calc_resp_encoder.sv
// calc_resp_encoder: queues ALU results and streams them as uppercase hex ASCII lines ending CR LF
module calc_resp_encoder
  import calc_pkg::*;
#(
  parameter int RES_W = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             alu_done,
  input  logic [RES_W-1:0] calc_res,
  input  logic             zsup,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             uout_valid,
  output logic             fifo_full,
  output logic             ovf
);
  localparam int NDIG = RES_W / 4;
  localparam int DW   = NDIG > 1 ? $clog2(NDIG) : 1;
  state_t state, state_n;
  logic [RES_W-1:0] sh, sh_n, dout;
  logic [DW-1:0] dcnt, dcnt_n;
  logic zs, zs_n, lead, lead_n, empty, pop, push, xfer, skip, valid_n;
  logic [3:0] nib_n;
  logic [7:0] data_n;
  calc_res_fifo #(.RES_W(RES_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .n_rst(n_rst), .push(push), .pop(pop), .din(calc_res),
    .dout(dout), .full(fifo_full), .empty(empty)
  );
  always_comb begin
    skip    = zs && lead && sh[RES_W-1 -: 4] == 4'd0 && dcnt != '0;
    xfer    = uout_valid && tx_ready;
    pop     = state == IDLE && !empty;
    push    = alu_done && (!fifo_full || pop);
    state_n = state;
    sh_n    = sh;
    zs_n    = zs;
    dcnt_n  = dcnt;
    lead_n  = lead;
    unique case (state)
      IDLE: if (!empty) begin
        state_n = DIGIT;
        sh_n    = dout;
        zs_n    = zsup;
        dcnt_n  = DW'(NDIG - 1);
        lead_n  = 1'b1;
      end
      DIGIT: if (skip || xfer) begin
        sh_n    = sh << 4;
        dcnt_n  = dcnt - 1'b1;
        lead_n  = skip;
        state_n = xfer && dcnt == '0 ? CR : DIGIT;
      end
      CR: state_n = xfer ? LF : CR;
      LF: state_n = xfer ? IDLE : LF;
    endcase
    // outputs are registered from the next state so the first digit appears right after the pop
    nib_n   = sh_n[RES_W-1 -: 4];
    valid_n = state_n == CR || state_n == LF ||
              (state_n == DIGIT && !(zs_n && lead_n && nib_n == 4'd0 && dcnt_n != '0));
    data_n  = state_n == CR ? ASC_CR : state_n == LF ? ASC_LF :
              state_n == DIGIT ? hex_asc(nib_n) : 8'h00;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state      <= IDLE;
      sh         <= '0;
      zs         <= 1'b0;
      dcnt       <= '0;
      lead       <= 1'b0;
      tx_data    <= 8'h00;
      uout_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      zs         <= zs_n;
      dcnt       <= dcnt_n;
      lead       <= lead_n;
      tx_data    <= data_n;
      uout_valid <= valid_n;
      ovf        <= ovf | (alu_done && fifo_full && !pop);
    end
endmodule

// File: tb/tb_calc_resp_encoder.sv
// tb_calc_resp_encoder: randomized and directed checks of the hex line encoder against a string-level model
module tb_calc_resp_encoder;
  localparam int RES_W = 32, DEPTH = 4, NDIG = RES_W / 4;
  logic clk = 0, n_rst = 0, alu_done = 0, zsup = 0, tx_ready = 0;
  logic [RES_W-1:0] calc_res = '0;
  logic [7:0] tx_data;
  logic uout_valid, fifo_full, ovf;
  int n_pass = 0, n_total = 0;
  logic [7:0] got[$], exp_q[$];

  calc_resp_encoder #(.RES_W(RES_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .alu_done(alu_done), .calc_res(calc_res), .zsup(zsup),
    .tx_ready(tx_ready), .tx_data(tx_data), .uout_valid(uout_valid),
    .fifo_full(fifo_full), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (n_rst && uout_valid && tx_ready) got.push_back(tx_data);
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic void add_line(input logic [RES_W-1:0] v, input bit zs);
    bit lead = zs;
    logic [3:0] d;
    for (int i = NDIG - 1; i >= 0; i--) begin
      d = v[4*i +: 4];
      if (lead && d == 4'd0 && i != 0) continue;
      lead = 0;
      exp_q.push_back(d < 4'd10 ? 8'h30 + {4'h0, d} : 8'h41 + {4'h0, d} - 8'd10);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [RES_W-1:0] v);
    alu_done = 1;
    calc_res = v;
    @(posedge clk);
    #1 alu_done = 0;
  endtask

  task automatic wait_bytes(input int n);
    for (int k = 0; k < 600 && got.size() < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    n_rst = 0;
    alu_done = 0;
    tx_ready = 0;
    zsup = 0;
    cycles(2);
    n_rst = 1;
    cycles(1);
    got.delete();
    exp_q.delete();
  endtask

  task automatic test_reset;
    do_reset();
    n_total++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data got %h exp 00", tx_data); else n_pass++;
    n_total++; if (uout_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", uout_valid); else n_pass++;
    n_total++; if (fifo_full !== 1'b0) $display("FAIL rst_full got %b exp 0", fifo_full); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL rst_ovf got %b exp 0", ovf); else n_pass++;
  endtask

  task automatic test_basic;
    tx_ready = 1;
    zsup = 0;
    push(32'h0000_1A2F);
    add_line(32'h0000_1A2F, 0);
    n_total++; if (uout_valid !== 1'b0) $display("FAIL latency_t1 got %b exp 0", uout_valid); else n_pass++;
    cycles(1);
    n_total++; if (uout_valid !== 1'b1 || tx_data !== 8'h30)
      $display("FAIL latency_t2 got %b/%h exp 1/30", uout_valid, tx_data); else n_pass++;
    wait_bytes(exp_q.size());
    zsup = 1;
    push(32'h0000_1A2F);
    push(32'h0);
    add_line(32'h0000_1A2F, 1);
    add_line(32'h0, 1);
    wait_bytes(exp_q.size());
    cycles(5);
    n_total++; if (got.size() != exp_q.size())
      $display("FAIL basic_len got %0d exp %0d", got.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_total++;
      if (i >= got.size() || got[i] !== exp_q[i])
        $display("FAIL basic_byte%0d got %h exp %h", i, i < got.size() ? got[i] : 8'hxx, exp_q[i]);
      else n_pass++;
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic test_backpressure;
    zsup = 0;
    tx_ready = 1;
    push(32'h0000_1A2F);
    add_line(32'h0000_1A2F, 0);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (uout_valid && tx_data == 8'h41) break;
    end
    tx_ready = 0;
    repeat (3) begin
      cycles(1);
      n_total++; if (uout_valid !== 1'b1 || tx_data !== 8'h41)
        $display("FAIL hold got %b/%h exp 1/41", uout_valid, tx_data); else n_pass++;
    end
    tx_ready = 1;
    wait_bytes(exp_q.size());
    cycles(5);
    n_total++; if (got.size() != exp_q.size())
      $display("FAIL bp_len got %0d exp %0d", got.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_total++;
      if (i >= got.size() || got[i] !== exp_q[i])
        $display("FAIL bp_byte%0d got %h exp %h", i, i < got.size() ? got[i] : 8'hxx, exp_q[i]);
      else n_pass++;
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic test_overflow;
    do_reset();
    push(32'h0);
    add_line(32'h0, 0);
    cycles(3);
    zsup = 1;
    for (int v = 1; v <= 6; v++) begin
      push(RES_W'(v));
      n_total++; if (fifo_full !== (v >= 4))
        $display("FAIL ovf_full_after%0d got %b exp %b", v, fifo_full, v >= 4); else n_pass++;
      n_total++; if (ovf !== (v >= 5))
        $display("FAIL ovf_flag_after%0d got %b exp %b", v, ovf, v >= 5); else n_pass++;
    end
    for (int v = 1; v <= 4; v++) add_line(RES_W'(v), 1);
    tx_ready = 1;
    wait_bytes(exp_q.size());
    cycles(20);
    n_total++; if (got.size() != exp_q.size())
      $display("FAIL ovf_len got %0d exp %0d", got.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_total++;
      if (i >= got.size() || got[i] !== exp_q[i])
        $display("FAIL ovf_byte%0d got %h exp %h", i, i < got.size() ? got[i] : 8'hxx, exp_q[i]);
      else n_pass++;
    end
    n_total++; if (ovf !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", ovf); else n_pass++;
  endtask

  task automatic test_full_pop;
    do_reset();
    zsup = 1;
    push(32'h5);
    add_line(32'h5, 1);
    cycles(3);
    for (int v = 1; v <= 4; v++) begin
      push(RES_W'(v));
      add_line(RES_W'(v), 1);
    end
    n_total++; if (fifo_full !== 1'b1) $display("FAIL fp_full_pre got %b exp 1", fifo_full); else n_pass++;
    tx_ready = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (uout_valid && tx_data == 8'h0A) break;
    end
    @(posedge clk);
    #1;
    alu_done = 1;
    calc_res = 32'h7;
    n_total++; if (fifo_full !== 1'b1) $display("FAIL fp_full_at_pop got %b exp 1", fifo_full); else n_pass++;
    cycles(1);
    alu_done = 0;
    add_line(32'h7, 1);
    n_total++; if (ovf !== 1'b0) $display("FAIL fp_ovf got %b exp 0", ovf); else n_pass++;
    n_total++; if (fifo_full !== 1'b1) $display("FAIL fp_full_post got %b exp 1", fifo_full); else n_pass++;
    wait_bytes(exp_q.size());
    cycles(10);
    n_total++; if (got.size() != exp_q.size())
      $display("FAIL fp_len got %0d exp %0d", got.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_total++;
      if (i >= got.size() || got[i] !== exp_q[i])
        $display("FAIL fp_byte%0d got %h exp %h", i, i < got.size() ? got[i] : 8'hxx, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    push(32'h0000_1A2F);
    cycles(3);
    for (int v = 1; v <= 5; v++) push(RES_W'(v));
    n_total++; if (ovf !== 1'b1 || uout_valid !== 1'b1)
      $display("FAIL rm_pre got %b/%b exp 1/1", ovf, uout_valid); else n_pass++;
    n_rst = 0;
    #1;
    n_total++; if (uout_valid !== 1'b0) $display("FAIL rm_valid got %b exp 0", uout_valid); else n_pass++;
    n_total++; if (tx_data !== 8'h00) $display("FAIL rm_data got %h exp 00", tx_data); else n_pass++;
    n_total++; if (fifo_full !== 1'b0) $display("FAIL rm_full got %b exp 0", fifo_full); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL rm_ovf got %b exp 0", ovf); else n_pass++;
    cycles(2);
    n_rst = 1;
    tx_ready = 1;
    got.delete();
    exp_q.delete();
    cycles(20);
    n_total++; if (got.size() != 0) $display("FAIL rm_residue got %0d exp 0", got.size()); else n_pass++;
    push(32'h0000_BEEF);
    add_line(32'h0000_BEEF, 0);
    wait_bytes(exp_q.size());
    cycles(5);
    n_total++; if (got.size() != exp_q.size())
      $display("FAIL rm_len got %0d exp %0d", got.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_total++;
      if (i >= got.size() || got[i] !== exp_q[i])
        $display("FAIL rm_byte%0d got %h exp %h", i, i < got.size() ? got[i] : 8'hxx, exp_q[i]);
      else n_pass++;
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic test_random_bursts;
    bit pv, pr;
    logic [7:0] pd;
    logic [RES_W-1:0] v;
    for (int b = 0; b < 12; b++) begin
      zsup = 1'($urandom);
      for (int j = 0; j < $urandom_range(1, 4); j++) begin
        v = $urandom >> $urandom_range(0, 31);
        push(v);
        add_line(v, zsup);
      end
      for (int k = 0; k < 1500 && got.size() < exp_q.size(); k++) begin
        tx_ready = 1'($urandom);
        pv = uout_valid;
        pd = tx_data;
        pr = tx_ready;
        cycles(1);
        if (pv && !pr) begin
          n_total++;
          if (uout_valid !== 1'b1 || tx_data !== pd)
            $display("FAIL rnd_stable got %b/%h exp 1/%h", uout_valid, tx_data, pd);
          else n_pass++;
        end
      end
    end
    tx_ready = 1;
    cycles(10);
    n_total++; if (got.size() != exp_q.size())
      $display("FAIL rnd_len got %0d exp %0d", got.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_total++;
      if (i >= got.size() || got[i] !== exp_q[i])
        $display("FAIL rnd_byte%0d got %h exp %h", i, i < got.size() ? got[i] : 8'hxx, exp_q[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random_bursts();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
